// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch PC sequencer.
// Owns the architectural fetch PC and keeps at most one instruction-memory request in flight.
// Applies branch redirects and drops responses made stale by a redirect.
// Hands {pc, inst} pairs to decode through a one-entry valid/ready buffer.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_branch_i_ifu,
  input  logic [XLEN-1:0]   dnpc_i_ifu,
  output logic              imem_req_o_ifu,
  output logic [XLEN-1:0]   imem_addr_o_ifu,
  input  logic              imem_gnt_i_ifu,
  input  logic              imem_rvalid_i_ifu,
  input  logic [INST_W-1:0] imem_rdata_i_ifu,
  output logic              inst_valid_o_ifu,
  input  logic              inst_ready_i_ifu,
  output logic [INST_W-1:0] inst_o_ifu,
  output logic [XLEN-1:0]   pc_o_ifu
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;

  logic [XLEN-1:0]   redirect_pc;
  logic [XLEN-1:0]   pc_inc;
  logic              dnpc_unused;

  // Redirect target is word aligned; sequential PC wraps modulo 2^XLEN.
  assign redirect_pc = {dnpc_i_ifu[XLEN-1:2], 2'b00};
  assign pc_inc      = pc_q + XLEN'(4);
  assign dnpc_unused = ^dnpc_i_ifu[1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i_ifu) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i_ifu) begin
          state_d = (kill_q || jump_branch_i_ifu) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (jump_branch_i_ifu || inst_ready_i_ifu) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Datapath and output next values: PC sequencing, kill tracking, buffer capture.
  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_gnt_i_ifu) begin
          fetch_pc_d = pc_q;
          kill_d     = jump_branch_i_ifu;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i_ifu) begin
          kill_d = 1'b0;
          if (!kill_q && !jump_branch_i_ifu) begin
            buf_inst_d = imem_rdata_i_ifu;
            buf_pc_d   = fetch_pc_q;
            pc_d       = pc_inc;
          end
        end else if (jump_branch_i_ifu) begin
          kill_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A redirect always wins over sequential advance, in every state.
    if (jump_branch_i_ifu) pc_d = redirect_pc;
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      kill_q     <= 1'b0;
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req_o_ifu   = req_q;
  assign imem_addr_o_ifu  = pc_q;
  assign inst_valid_o_ifu = valid_q;
  assign inst_o_ifu       = buf_inst_q;
  assign pc_o_ifu         = buf_pc_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch PC sequencer at the receiving end of the branch-redirect interface.
- Consumes the branch unit's taken flag (jump_branch) and target (dnpc), owns the architectural fetch PC, and issues single-outstanding requests to instruction memory.
- Delivers {pc, inst} pairs to decode over a valid/ready handshake.
- Drops fetch responses made stale by a redirect.

Parameters:
- XLEN, 64, PC / address / target width.
- INST_W, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- jump_branch_i_ifu  input  1  redirect request, sampled every rising edge.
- dnpc_i_ifu  input  XLEN  redirect target; bits [1:0] are ignored.
- imem_req_o_ifu  output  1  fetch request valid.
- imem_addr_o_ifu  output  XLEN  fetch address, always equal to pc.
- imem_gnt_i_ifu  input  1  request accepted this cycle.
- imem_rvalid_i_ifu  input  1  response valid.
- imem_rdata_i_ifu  input  INST_W  response instruction.
- inst_valid_o_ifu  output  1  instruction available to decode.
- inst_ready_i_ifu  input  1  decode accepts.
- inst_o_ifu  output  INST_W  buffered instruction.
- pc_o_ifu  output  XLEN  PC of the buffered instruction.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- While rst_n=0:
  - state=BOOT, pc=RESET_PC, kill=0, buffer invalid.
  - imem_req_o_ifu=0, inst_valid_o_ifu=0, inst_o_ifu=0, pc_o_ifu=0.
- States:
  - BOOT -> REQ on the first edge after release.
  - REQ: imem_req_o_ifu=1. On gnt: latch fetch_pc=pc, go to WAIT.
  - WAIT: wait for rvalid.
    - rvalid with kill=0: capture rdata and fetch_pc into the buffer, pc<=pc+4, go to HOLD.
    - rvalid with kill=1: discard the response, clear kill, go to REQ.
  - HOLD: inst_valid_o_ifu=1. On inst_ready_i_ifu go to REQ.
- Memory protocol: at most one outstanding request. rvalid never asserts in the same cycle as its gnt, and is ignored outside WAIT.
- Redirect (jump_branch_i_ifu=1 at an edge) always sets pc<={dnpc_i_ifu[XLEN-1:2],2'b00}, and overrides pc+4. Per state:
  - REQ without gnt: stay in REQ. The new address is presented the next cycle. Changing the address of an ungranted request is legal.
  - REQ with gnt in the same cycle: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1.
  - WAIT with rvalid in the same cycle: discard the response, go to REQ, kill=0.
  - HOLD: invalidate the buffer and go to REQ. If inst_ready_i_ifu is also high, the handshake completes: the instruction counts as delivered, and the redirect still applies.
  - A second redirect while kill=1 updates pc; kill stays set.
  - BOOT: update pc.
- inst_o_ifu and pc_o_ifu hold stable while inst_valid_o_ifu=1 and inst_ready_i_ifu=0.
- PC arithmetic is modulo 2^XLEN: pc+4 wraps to 0 without a flag. pc[1:0] is always 0.
- Latency with a zero-wait memory (gnt in REQ, rvalid on the next cycle): REQ, WAIT, HOLD give 3 cycles per instruction with ready held high. A redirect at edge N presents dnpc on imem_addr_o_ifu during cycle N+1 (from REQ or HOLD).
- Reset asserted mid-operation: immediate return to BOOT. Any in-flight response is ignored, because rvalid is ignored outside WAIT.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> req=0, valid=0. The cycle after the first post-release edge -> req=1, addr=0x80000000.
- Sequential fetch: the memory grants immediately and returns 0x00000013, 0x00100093, 0x00200113 -> decode sees (0x80000000,0x00000013), (0x80000004,0x00100093), (0x80000008,0x00200113), each valid every 3rd cycle with ready=1.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> valid stays 1, pc_o/inst_o are unchanged, req=0. After ready=1, the next addr is 0x80000004.
- Stale drop: redirect dnpc=0x80001002 while in WAIT; the memory then returns 0xDEADBEEF -> 0xDEADBEEF is never presented, and the next addr is 0x80001000.
- Redirect in HOLD with ready=0, dnpc=0x80000100 -> valid=0 on the next cycle, req=1 with addr=0x80000100. Variant: redirect with rvalid in the same cycle in WAIT -> the response is discarded, and the next req goes to the target.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> the first instruction is at pc 0xFFFF_FFFF_FFFF_FFFC, and the second fetch addr is 0x0.
